// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel-index width: never narrower than one bit.
  function automatic int sw_of(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Stream mux bus: N producer channels in, one consumer stream out.
// STREAM_MUX_LAST_EN adds in_last / out_last packet delimiters.
interface stream_mux_if
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = sw_of(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_ch;
  logic           out_ready;
`ifdef STREAM_MUX_LAST_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  // Environment side: producers, consumer and control.
  modport master (
    output in_data, in_valid, sel, mode, out_ready,
`ifdef STREAM_MUX_LAST_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_data, out_valid, out_ch
  );

  // Mux side.
  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
`ifdef STREAM_MUX_LAST_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority arbiter: first set req bit at or after ptr, wrapping.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  // Walk channels from ptr upward, taking the first requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx[SW-1:0];
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux, manual-select or round-robin,
// registered output stage. STREAM_MUX_LAST_EN adds packet locking.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  stream_mux_if.slave bus
);

  localparam int SW = sw_of(N);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [W-1:0]  data_q, data_d;
  logic          vld_q, vld_d;
  logic [N-1:0]  req, gnt;
  logic [SW-1:0] gnt_idx, ptr_nxt;
  logic          any, free, xfer;
`ifdef STREAM_MUX_LAST_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
  logic          last_q, last_d;
`endif

  // Eligible requesters: a held packet lock overrides mode/sel.
  always_comb begin
    req = '0;
    if (bus.mode == MODE_RR) req = bus.in_valid;
    else if (int'(bus.sel) < N) req[bus.sel] = bus.in_valid[bus.sel];
`ifdef STREAM_MUX_LAST_EN
    if (lock_q) begin
      req            = '0;
      req[lock_ch_q] = bus.in_valid[lock_ch_q];
    end
`endif
  end

  // In manual/locked mode only one bit of req can be set, so the start
  // point is irrelevant and ptr_q can feed the arbiter unconditionally.
  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign free    = !vld_q || bus.out_ready;
  assign xfer    = any && free && !rst;
  assign ptr_nxt = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

  assign bus.in_ready  = xfer ? gnt : '0;
  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.out_ch    = ch_q;
`ifdef STREAM_MUX_LAST_EN
  assign bus.out_last  = last_q;
`endif

  // Output register load, pointer advance and lock tracking.
  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
`ifdef STREAM_MUX_LAST_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    last_d    = last_q;
`endif
    if (free) vld_d = xfer;
    if (xfer) begin
      data_d = bus.in_data[int'(gnt_idx)*W +: W];
      ch_d   = gnt_idx;
`ifdef STREAM_MUX_LAST_EN
      last_d    = bus.in_last[gnt_idx];
      lock_d    = !bus.in_last[gnt_idx];
      lock_ch_d = gnt_idx;
      if (bus.mode == MODE_RR && bus.in_last[gnt_idx]) ptr_d = ptr_nxt;
`else
      if (bus.mode == MODE_RR) ptr_d = ptr_nxt;
`endif
    end
  end

  // State flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 1'b0;
      data_q    <= '0;
      ch_q      <= '0;
      ptr_q     <= '0;
`ifdef STREAM_MUX_LAST_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      last_q    <= 1'b0;
`endif
    end else begin
      vld_q     <= vld_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
`ifdef STREAM_MUX_LAST_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: table of single-cycle vectors plus
// hand-written backpressure, reset-pulse, N=3 and packet-lock sequences.
module tb_stream_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_if #(.N(4), .W(8)) b4 ();
  stream_mux_if #(.N(3), .W(8)) b3 ();

  stream_mux #(.N(4), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  stream_mux #(.N(3), .W(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[16];
  int   total  = 0;
  int   passed = 0;
  int   q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // One clock with scoreboard bookkeeping just before the edge.
  task automatic sb_cyc();
    int e;
    #1;
    for (int k = 0; k < 4; k++) if (b4.in_ready[k]) q.push_back(k);
    if (b4.out_valid && b4.out_ready) begin
      if (q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_ch", 32'(b4.out_ch), 32'(e));
        chk("sb_data", 32'(b4.out_data), 32'(8'hA0 + e));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Manual sel=2, sel switch, rr all valid, rr with ch1 dropped, idle.
    tbl[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[3]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[8]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[9]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[10] = '{1'b1, 2'd0, 4'hD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[11] = '{1'b1, 2'd0, 4'hD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[12] = '{1'b1, 2'd0, 4'hD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[13] = '{1'b1, 2'd0, 4'hD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[14] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
    tbl[15] = '{1'b0, 2'd1, 4'hD, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};

    rst = 1'b1;
    b4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b4.in_valid = 4'hF; b4.mode = 1'b1; b4.sel = 2'd0; b4.out_ready = 1'b1;
    b3.in_data = {8'hB2, 8'hB1, 8'hB0};
    b3.in_valid = 3'b111; b3.mode = 1'b0; b3.sel = 2'd3; b3.out_ready = 1'b1;
`ifdef STREAM_MUX_LAST_EN
    b4.in_last = 4'hF; b3.in_last = 3'b111;
`endif

    // Reset with every channel requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(b4.in_ready), 0);
    chk("rst_out_valid", 32'(b4.out_valid), 0);
    chk("rst_out_data", 32'(b4.out_data), 0);
    chk("rst_out_ch", 32'(b4.out_ch), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      b4.mode = tbl[i].mode; b4.sel = tbl[i].sel;
      b4.in_valid = tbl[i].vld; b4.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(b4.in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(b4.out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("vec%0d_out_ch", i), 32'(b4.out_ch), 32'(tbl[i].exp_ch));
      chk($sformatf("vec%0d_out_data", i), 32'(b4.out_data), 32'(tbl[i].exp_data));
    end

    // N=3 with sel=3: nothing eligible throughout the run so far.
    chk("n3_sel3_in_ready", 32'(b3.in_ready), 0);
    chk("n3_sel3_out_valid", 32'(b3.out_valid), 0);

    // Backpressure: ptr is at 3, so ch3 loads first then stalls.
    b4.mode = 1'b1; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    sb_cyc();
    chk("bp_load_ch", 32'(b4.out_ch), 3);
    b4.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb_cyc();
      chk($sformatf("bp%0d_in_ready", i), 32'(b4.in_ready), 0);
      chk($sformatf("bp%0d_out_valid", i), 32'(b4.out_valid), 1);
      chk($sformatf("bp%0d_out_ch", i), 32'(b4.out_ch), 3);
      chk($sformatf("bp%0d_out_data", i), 32'(b4.out_data), 32'h A3);
    end
    b4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_cyc();
      chk($sformatf("rel%0d_out_ch", i), 32'(b4.out_ch), 32'(i));
    end
    b4.in_valid = 4'h0;
    sb_cyc();
    chk("sb_empty", 32'(q.size()), 0);
    chk("drain_out_valid", 32'(b4.out_valid), 0);

    // Reset pulse while a beat is held and ptr has moved to 1.
    b4.in_valid = 4'hF;
    sb_cyc();
    q.delete();
    chk("pre_rst_out_valid", 32'(b4.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_pulse_in_ready", 32'(b4.in_ready), 0);
    @(posedge clk); #1;
    chk("rst_pulse_out_valid", 32'(b4.out_valid), 0);
    chk("rst_pulse_out_ch", 32'(b4.out_ch), 0);
    rst = 1'b0;
    #1;
    chk("rst_pulse_ptr0", 32'(b4.in_ready), 32'b0001);

`ifdef STREAM_MUX_LAST_EN
    // Packet lock: ch0 3-beat packet while ch1 also requests.
    b4.in_valid = 4'b0011;
    b4.in_last = 4'b0000; #1;
    @(posedge clk); #1;
    chk("pkt0_ch", 32'(b4.out_ch), 0); chk("pkt0_last", 32'(b4.out_last), 0);
    chk("pkt1_in_ready", 32'(b4.in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("pkt1_ch", 32'(b4.out_ch), 0); chk("pkt1_last", 32'(b4.out_last), 0);
    b4.in_last = 4'b0001;
    @(posedge clk); #1;
    chk("pkt2_ch", 32'(b4.out_ch), 0); chk("pkt2_last", 32'(b4.out_last), 1);
    b4.in_last = 4'b0000;
    @(posedge clk); #1;
    chk("pkt3_ch", 32'(b4.out_ch), 1); chk("pkt3_last", 32'(b4.out_last), 0);
`endif

    // N=3 with a valid sel still works.
    b3.sel = 2'd1;
    #1;
    chk("n3_sel1_in_ready", 32'(b3.in_ready), 32'b010);
    @(posedge clk); #1;
    chk("n3_sel1_out_valid", 32'(b3.out_valid), 1);
    chk("n3_sel1_out_data", 32'(b3.out_data), 32'hB1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
